// File: rtl/hex_pkg.sv
// Shared constants and the seven-segment font for the hex display controller.
package hex_pkg;

    localparam int unsigned SEG_W = 7;
    localparam int unsigned NIB_W = 4;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

    // Active-low gfedcba pattern for one hex nibble.
    function automatic logic [SEG_W-1:0] hex_font(input logic [NIB_W-1:0] nib);
        logic [SEG_W-1:0] seg;
        case (nib)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/hex_digit_font.sv
// Combinational nibble to active-low seven-segment pattern.
module hex_digit_font
    import hex_pkg::*;
(
    input  logic [NIB_W-1:0] nib,
    output logic [SEG_W-1:0] seg_c
);

    // Pure font lookup; blanking is applied by the caller.
    always_comb begin
        seg_c = hex_font(nib);
    end

endmodule

// File: rtl/hex_display_ctrl.sv
// Multi-digit seven-segment controller: latched value, leading-zero blanking,
// per-digit blinking from a free-running divider, registered segment outputs.
module hex_display_ctrl
    import hex_pkg::*;
#(
    parameter int unsigned DIGITS    = 6,
    parameter int unsigned BLINK_DIV = 25000000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      load,
    input  logic [NIB_W*DIGITS-1:0]   value,
    input  logic                      blank_lz,
    input  logic [DIGITS-1:0]         blink_mask,
    input  logic                      blink_clr,
    output logic                      blink_phase,
    output logic [SEG_W*DIGITS-1:0]   seg_out
);

    localparam int unsigned VAL_W = NIB_W * DIGITS;
    localparam int unsigned OUT_W = SEG_W * DIGITS;
    localparam int unsigned CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

    logic [VAL_W-1:0] value_q, value_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             phase_q, phase_d;
    logic [OUT_W-1:0] seg_q, seg_d;

    logic [SEG_W-1:0] font_w [DIGITS];
    logic [DIGITS-1:0] lz_blank;

    // One font decoder per digit, fed from the latched value.
    for (genvar g = 0; g < int'(DIGITS); g++) begin : g_font
        hex_digit_font u_font (
            .nib   (value_q[g*NIB_W +: NIB_W]),
            .seg_c (font_w[g])
        );
    end

    // Value capture on the load strobe.
    always_comb begin
        value_d = value_q;
        if (load) begin
            value_d = value;
        end
    end

    // Blink divider: wraps at BLINK_DIV-1 and toggles the phase; clear wins.
    always_comb begin
        cnt_d   = cnt_q + CNT_W'(1);
        phase_d = phase_q;
        if (blink_clr) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end
    end

    // Leading-zero mask (scanning from the top digit) and per-digit priority mux.
    always_comb begin
        logic all_zero;
        all_zero = 1'b1;
        lz_blank = '0;
        seg_d    = '0;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            all_zero    = all_zero & (value_q[i*NIB_W +: NIB_W] == '0);
            lz_blank[i] = blank_lz & all_zero & (i != 0);
        end
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (!en || lz_blank[i] || (blink_mask[i] && phase_q)) begin
                seg_d[i*SEG_W +: SEG_W] = SEG_BLANK;
            end else begin
                seg_d[i*SEG_W +: SEG_W] = font_w[i];
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= '0;
            cnt_q   <= '0;
            phase_q <= 1'b0;
            seg_q   <= '1;
        end else begin
            value_q <= value_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            seg_q   <= seg_d;
        end
    end

    assign seg_out     = seg_q;
    assign blink_phase = phase_q;

endmodule
